// File: rtl/e_ctrl_md.sv
// Execute-stage controller: ALU control decode plus a multi-cycle multiply/divide
// sequencer owning HI/LO, with a stall request while an MD operation is in flight.
module e_ctrl_md #(
    parameter int ALUOP_W     = 4,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [31:0]        IR,
    input  logic               valid,
    input  logic [31:0]        A,
    input  logic [31:0]        B,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic               BSel,
    output logic               ShSel,
    output logic               ResSel,
    output logic [31:0]        md_out,
    output logic               md_busy,
    output logic               md_stall,
    output logic [31:0]        hi,
    output logic [31:0]        lo
);

    localparam logic [ALUOP_W-1:0] ALU_ADD  = ALUOP_W'(0);
    localparam logic [ALUOP_W-1:0] ALU_SUB  = ALUOP_W'(1);
    localparam logic [ALUOP_W-1:0] ALU_OR   = ALUOP_W'(2);
    localparam logic [ALUOP_W-1:0] ALU_AND  = ALUOP_W'(3);
    localparam logic [ALUOP_W-1:0] ALU_XOR  = ALUOP_W'(4);
    localparam logic [ALUOP_W-1:0] ALU_NOR  = ALUOP_W'(5);
    localparam logic [ALUOP_W-1:0] ALU_SLT  = ALUOP_W'(6);
    localparam logic [ALUOP_W-1:0] ALU_SLTU = ALUOP_W'(7);
    localparam logic [ALUOP_W-1:0] ALU_SLL  = ALUOP_W'(8);
    localparam logic [ALUOP_W-1:0] ALU_SRL  = ALUOP_W'(9);
    localparam logic [ALUOP_W-1:0] ALU_SRA  = ALUOP_W'(10);
    localparam logic [ALUOP_W-1:0] ALU_LUI  = ALUOP_W'(11);

    localparam logic [CNT_W-1:0] MULT_N = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_N  = CNT_W'(DIV_CYCLES);

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_BUSY = 1'b1} md_state_t;

    logic [5:0]  op_s;
    logic [5:0]  funct_s;
    logic        rtype_s;
    logic        is_muldiv_s;
    logic        is_mfhi_s;
    logic        is_mflo_s;
    logic        is_mthi_s;
    logic        is_mtlo_s;
    logic        is_md_instr_s;
    logic        start_s;
    logic        unused_ir_s;

    md_state_t        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       op_q;
    logic [31:0]      a_q;
    logic [31:0]      b_q;
    logic [31:0]      hi_q;
    logic [31:0]      lo_q;

    logic        sdiv_s;
    logic [31:0] mag_a_s;
    logic [31:0] mag_b_s;
    logic [31:0] den_s;
    logic [31:0] uq_s;
    logic [31:0] ur_s;
    logic [31:0] sq_s;
    logic [31:0] sr_s;
    logic [63:0] res_s;

    assign op_s          = IR[31:26];
    assign funct_s       = IR[5:0];
    assign unused_ir_s   = ^IR[25:6];
    assign rtype_s       = (op_s == 6'b000000);
    assign is_muldiv_s   = rtype_s && (funct_s[5:2] == 4'b0110);
    assign is_mfhi_s     = rtype_s && (funct_s == 6'b010000);
    assign is_mthi_s     = rtype_s && (funct_s == 6'b010001);
    assign is_mflo_s     = rtype_s && (funct_s == 6'b010010);
    assign is_mtlo_s     = rtype_s && (funct_s == 6'b010011);
    assign is_md_instr_s = is_muldiv_s | is_mfhi_s | is_mflo_s | is_mthi_s | is_mtlo_s;

    assign md_busy  = (state_q == ST_BUSY);
    assign start_s  = valid & is_muldiv_s & ~md_busy;
    assign md_stall = valid & is_md_instr_s & md_busy;
    assign hi       = hi_q;
    assign lo       = lo_q;

    // ALU control decode from the E-stage opcode/funct
    always_comb begin
        ALUOp  = ALU_ADD;
        BSel   = 1'b0;
        ShSel  = 1'b0;
        ResSel = 1'b0;
        if (rtype_s) begin
            case (funct_s)
                6'b100001: ALUOp = ALU_ADD;
                6'b100011: ALUOp = ALU_SUB;
                6'b100100: ALUOp = ALU_AND;
                6'b100101: ALUOp = ALU_OR;
                6'b100110: ALUOp = ALU_XOR;
                6'b100111: ALUOp = ALU_NOR;
                6'b101010: ALUOp = ALU_SLT;
                6'b101011: ALUOp = ALU_SLTU;
                6'b000000: begin ALUOp = ALU_SLL; ShSel = 1'b1; end
                6'b000010: begin ALUOp = ALU_SRL; ShSel = 1'b1; end
                6'b000011: begin ALUOp = ALU_SRA; ShSel = 1'b1; end
                6'b010000: ResSel = 1'b1;
                6'b010010: ResSel = 1'b1;
                default:   ALUOp = ALU_ADD;
            endcase
        end else begin
            case (op_s)
                6'b001101: begin ALUOp = ALU_OR;   BSel = 1'b1; end
                6'b001100: begin ALUOp = ALU_AND;  BSel = 1'b1; end
                6'b001110: begin ALUOp = ALU_XOR;  BSel = 1'b1; end
                6'b001001: begin ALUOp = ALU_ADD;  BSel = 1'b1; end
                6'b001010: begin ALUOp = ALU_SLT;  BSel = 1'b1; end
                6'b001011: begin ALUOp = ALU_SLTU; BSel = 1'b1; end
                6'b001111: begin ALUOp = ALU_LUI;  BSel = 1'b1; end
                6'b100011: begin ALUOp = ALU_ADD;  BSel = 1'b1; end
                6'b101011: begin ALUOp = ALU_ADD;  BSel = 1'b1; end
                default:   ALUOp = ALU_ADD;
            endcase
        end
    end

    // HI/LO read port for mfhi/mflo
    always_comb begin
        if (is_mfhi_s) begin
            md_out = hi_q;
        end else if (is_mflo_s) begin
            md_out = lo_q;
        end else begin
            md_out = 32'd0;
        end
    end

    // Result datapath on latched operands; divide works on magnitudes and restores signs.
    // 0x80000000 / -1 falls out naturally as quotient 0x80000000, remainder 0.
    always_comb begin
        sdiv_s  = (op_q == 2'b10);
        mag_a_s = (sdiv_s && a_q[31]) ? (32'd0 - a_q) : a_q;
        mag_b_s = (sdiv_s && b_q[31]) ? (32'd0 - b_q) : b_q;
        den_s   = (mag_b_s == 32'd0) ? 32'd1 : mag_b_s;
        uq_s    = mag_a_s / den_s;
        ur_s    = mag_a_s % den_s;
        sq_s    = (sdiv_s && (a_q[31] ^ b_q[31])) ? (32'd0 - uq_s) : uq_s;
        sr_s    = (sdiv_s && a_q[31]) ? (32'd0 - ur_s) : ur_s;
        case (op_q)
            2'b00:   res_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
            2'b01:   res_s = {32'd0, a_q} * {32'd0, b_q};
            default: res_s = (b_q == 32'd0) ? {a_q, 32'hFFFF_FFFF} : {sr_s, sq_s};
        endcase
    end

    // MD sequencer: start/latch, countdown, commit; mthi/mtlo only while idle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            op_q    <= 2'b00;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_s) begin
                        state_q <= ST_BUSY;
                        cnt_q   <= funct_s[1] ? DIV_N : MULT_N;
                        op_q    <= funct_s[1:0];
                        a_q     <= A;
                        b_q     <= B;
                    end else if (valid && is_mthi_s) begin
                        hi_q <= A;
                    end else if (valid && is_mtlo_s) begin
                        lo_q <= A;
                    end else begin
                        cnt_q <= {CNT_W{1'b0}};
                    end
                end
                ST_BUSY: begin
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= {CNT_W{1'b0}};
                        hi_q    <= res_s[63:32];
                        lo_q    <= res_s[31:0];
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

endmodule

// File: tb/tb_e_ctrl_md.sv
// Directed + randomized bench for e_ctrl_md; HI/LO results come from a
// 64-bit arithmetic reference model, decode from a constant table.
module tb_e_ctrl_md;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] IR;
    logic        valid;
    logic [31:0] A;
    logic [31:0] B;
    logic [3:0]  ALUOp;
    logic        BSel;
    logic        ShSel;
    logic        ResSel;
    logic [31:0] md_out;
    logic        md_busy;
    logic        md_stall;
    logic [31:0] hi;
    logic [31:0] lo;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [31:0] exp_hi   = 32'd0;
    logic [31:0] exp_lo   = 32'd0;

    always #5 clk = ~clk;

    e_ctrl_md #(
        .ALUOP_W(4), .MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N), .CNT_W(4)
    ) dut (
        .clk(clk), .reset_n(reset_n), .IR(IR), .valid(valid), .A(A), .B(B),
        .ALUOp(ALUOp), .BSel(BSel), .ShSel(ShSel), .ResSel(ResSel),
        .md_out(md_out), .md_busy(md_busy), .md_stall(md_stall),
        .hi(hi), .lo(lo)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rtype(input logic [5:0] funct);
        return {6'd0, 20'($urandom), funct};
    endfunction

    // Reference: {hi, lo} from plain integer arithmetic
    function automatic logic [63:0] md_ref(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        longint      sp;
        logic [63:0] up;
        int          sa;
        int          sb;
        sa = a;
        sb = b;
        if (f == F_MULT) begin
            sp = longint'(sa) * longint'(sb);
            return sp;
        end else if (f == F_MULTU) begin
            up = {32'd0, a} * {32'd0, b};
            return up;
        end else if (b == 32'd0) begin
            return {a, 32'hFFFF_FFFF};
        end else if (f == F_DIV && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            return {32'd0, 32'h8000_0000};
        end else if (f == F_DIV) begin
            return {32'(sa % sb), 32'(sa / sb)};
        end else begin
            return {a % b, a / b};
        end
    endfunction

    function automatic int cycles_of(input logic [5:0] f);
        return (f == F_DIV || f == F_DIVU) ? DIV_N : MULT_N;
    endfunction

    task automatic dchk(input string tag, input logic [5:0] op, input logic [5:0] funct,
                        input logic [3:0] alu, input logic bs, input logic sh, input logic rs);
        IR    = {op, 20'($urandom), funct};
        valid = 1'b0;
        #1;
        chk(tag, 64'({ALUOp, BSel, ShSel, ResSel}), 64'({alu, bs, sh, rs}));
    endtask

    // Count busy cycles, checking stall and HI/LO hold, then check the committed result
    task automatic drain(input string tag, input int n_exp, input logic [63:0] r, input logic stall_exp);
        int cnt = 0;
        while (md_busy === 1'b1 && cnt < 40) begin
            cnt++;
            chk({tag, "_stall"}, 64'(md_stall), 64'(stall_exp));
            chk({tag, "_hold"}, {hi, lo}, {exp_hi, exp_lo});
            step();
        end
        chk({tag, "_cycles"}, 64'(cnt), 64'(n_exp));
        exp_hi = r[63:32];
        exp_lo = r[31:0];
        chk({tag, "_hilo"}, {hi, lo}, r);
    endtask

    task automatic run_md(input string tag, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] r;
        r     = md_ref(f, a, b);
        IR    = rtype(f);
        A     = a;
        B     = b;
        valid = 1'b1;
        #1;
        chk({tag, "_idle"}, 64'({md_busy, md_stall}), 64'd0);
        step();
        valid = 1'b0;
        A     = $urandom;
        B     = $urandom;
        #1;
        chk({tag, "_busy"}, 64'(md_busy), 64'd1);
        drain(tag, cycles_of(f), r, 1'b0);
    endtask

    task automatic mt(input string tag, input logic is_hi, input logic [31:0] a);
        IR    = rtype(is_hi ? F_MTHI : F_MTLO);
        A     = a;
        valid = 1'b1;
        step();
        valid = 1'b0;
        if (is_hi) exp_hi = a;
        else       exp_lo = a;
        chk(tag, {hi, lo}, {exp_hi, exp_lo});
    endtask

    initial begin
        logic [63:0] r1;
        logic [63:0] r2;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [5:0]  rf;
        int          sel;

        reset_n = 1'b0;
        valid   = 1'b0;
        IR      = 32'd0;
        A       = 32'd0;
        B       = 32'd0;
        #3;
        chk("reset_state", {32'(md_busy), 32'(md_stall)}, 64'd0);
        chk("reset_hilo", {hi, lo}, 64'd0);
        step();
        @(negedge clk);
        reset_n = 1'b1;
        step();

        // Decode sweep
        dchk("d_addu",  6'h00, 6'h21, 4'd0,  1'b0, 1'b0, 1'b0);
        dchk("d_subu",  6'h00, 6'h23, 4'd1,  1'b0, 1'b0, 1'b0);
        dchk("d_and",   6'h00, 6'h24, 4'd3,  1'b0, 1'b0, 1'b0);
        dchk("d_or",    6'h00, 6'h25, 4'd2,  1'b0, 1'b0, 1'b0);
        dchk("d_xor",   6'h00, 6'h26, 4'd4,  1'b0, 1'b0, 1'b0);
        dchk("d_nor",   6'h00, 6'h27, 4'd5,  1'b0, 1'b0, 1'b0);
        dchk("d_slt",   6'h00, 6'h2A, 4'd6,  1'b0, 1'b0, 1'b0);
        dchk("d_sltu",  6'h00, 6'h2B, 4'd7,  1'b0, 1'b0, 1'b0);
        dchk("d_sll",   6'h00, 6'h00, 4'd8,  1'b0, 1'b1, 1'b0);
        dchk("d_srl",   6'h00, 6'h02, 4'd9,  1'b0, 1'b1, 1'b0);
        dchk("d_sra",   6'h00, 6'h03, 4'd10, 1'b0, 1'b1, 1'b0);
        dchk("d_mfhi",  6'h00, 6'h10, 4'd0,  1'b0, 1'b0, 1'b1);
        dchk("d_mflo",  6'h00, 6'h12, 4'd0,  1'b0, 1'b0, 1'b1);
        dchk("d_jr",    6'h00, 6'h08, 4'd0,  1'b0, 1'b0, 1'b0);
        dchk("d_mult",  6'h00, 6'h18, 4'd0,  1'b0, 1'b0, 1'b0);
        dchk("d_ori",   6'h0D, 6'($urandom), 4'd2,  1'b1, 1'b0, 1'b0);
        dchk("d_andi",  6'h0C, 6'($urandom), 4'd3,  1'b1, 1'b0, 1'b0);
        dchk("d_xori",  6'h0E, 6'($urandom), 4'd4,  1'b1, 1'b0, 1'b0);
        dchk("d_addiu", 6'h09, 6'($urandom), 4'd0,  1'b1, 1'b0, 1'b0);
        dchk("d_slti",  6'h0A, 6'($urandom), 4'd6,  1'b1, 1'b0, 1'b0);
        dchk("d_sltiu", 6'h0B, 6'($urandom), 4'd7,  1'b1, 1'b0, 1'b0);
        dchk("d_lui",   6'h0F, 6'($urandom), 4'd11, 1'b1, 1'b0, 1'b0);
        dchk("d_lw",    6'h23, 6'($urandom), 4'd0,  1'b1, 1'b0, 1'b0);
        dchk("d_sw",    6'h2B, 6'($urandom), 4'd0,  1'b1, 1'b0, 1'b0);
        dchk("d_beq",   6'h04, 6'h21, 4'd0,  1'b0, 1'b0, 1'b0);
        dchk("d_bne",   6'h05, 6'h2A, 4'd0,  1'b0, 1'b0, 1'b0);
        dchk("d_jal",   6'h03, 6'h03, 4'd0,  1'b0, 1'b0, 1'b0);
        dchk("d_unk",   6'h3F, 6'h10, 4'd0,  1'b0, 1'b0, 1'b0);
        step();

        // mthi/mtlo while idle, and md_out read-back
        mt("mthi_idle", 1'b1, 32'h0000_1234);
        mt("mtlo_idle", 1'b0, 32'hA5A5_0F0F);
        IR = rtype(F_MFHI); #1;
        chk("mfhi_out", 64'(md_out), 64'(exp_hi));
        IR = rtype(F_MFLO); #1;
        chk("mflo_out", 64'(md_out), 64'(exp_lo));
        IR = rtype(6'h21); #1;
        chk("md_out_zero", 64'(md_out), 64'd0);
        IR = rtype(F_MTHI); A = 32'hDEAD_BEEF; valid = 1'b0;
        step();
        chk("mthi_invalid", 64'(hi), 64'(exp_hi));

        // valid=0 with mult IR never starts
        IR = rtype(F_MULT); valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bubble_no_start", 64'(md_busy), 64'd0);
        end

        // Directed MD results
        run_md("mult",  F_MULT,  32'hFFFF_FFFE, 32'd3);
        chk("mult_const", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFA});
        run_md("multu", F_MULTU, 32'hFFFF_FFFE, 32'd3);
        chk("multu_const", {hi, lo}, {32'h0000_0002, 32'hFFFF_FFFA});
        run_md("div",   F_DIV,   32'hFFFF_FFF9, 32'd2);
        chk("div_const", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        run_md("divu0", F_DIVU,  32'd7, 32'd0);
        chk("divu0_const", {hi, lo}, {32'd7, 32'hFFFF_FFFF});
        run_md("div0",  F_DIV,   32'hFFFF_FF00, 32'd0);
        run_md("divov", F_DIV,   32'h8000_0000, 32'hFFFF_FFFF);
        chk("divov_const", {hi, lo}, {32'd0, 32'h8000_0000});

        // mult followed by mflo: stall for all busy cycles, then new lo
        r1 = md_ref(F_MULT, 32'h0001_2345, 32'h0000_0100);
        IR = rtype(F_MULT); A = 32'h0001_2345; B = 32'h0000_0100; valid = 1'b1;
        step();
        IR = rtype(F_MFLO); A = $urandom; #1;
        chk("mflo_old_lo", 64'(md_out), 64'(exp_lo));
        drain("mflo_stall", MULT_N, r1, 1'b1);
        chk("mflo_unstall", 64'({md_stall, ResSel}), 64'({1'b0, 1'b1}));
        chk("mflo_new_lo", 64'(md_out), 64'(r1[31:0]));
        valid = 1'b0;
        step();

        // mult presented while busy: no restart, then starts on the first idle cycle
        r1 = md_ref(F_MULTU, 32'h0000_ABCD, 32'h0001_0001);
        r2 = md_ref(F_MULT,  32'h8765_4321, 32'hFFFF_FF00);
        IR = rtype(F_MULTU); A = 32'h0000_ABCD; B = 32'h0001_0001; valid = 1'b1;
        step();
        IR = rtype(F_MULT); A = 32'h8765_4321; B = 32'hFFFF_FF00; #1;
        drain("norestart1", MULT_N, r1, 1'b1);
        chk("norestart_idle", 64'({md_busy, md_stall}), 64'd0);
        step();
        valid = 1'b0; A = $urandom; B = $urandom; #1;
        chk("b2b_busy", 64'(md_busy), 64'd1);
        drain("norestart2", MULT_N, r2, 1'b0);

        // mthi while busy is held off, then written on the cycle after commit
        r1 = md_ref(F_DIV, 32'd100, 32'd7);
        IR = rtype(F_DIV); A = 32'd100; B = 32'd7; valid = 1'b1;
        step();
        IR = rtype(F_MTHI); A = 32'h0000_CAFE; #1;
        drain("mthi_busy", DIV_N, r1, 1'b1);
        chk("div_100_7", {hi, lo}, {32'd2, 32'd14});
        step();
        valid = 1'b0;
        exp_hi = 32'h0000_CAFE;
        chk("mthi_after", 64'(hi), 64'(exp_hi));

        // Randomized MD ops and moves against the reference model
        for (int i = 0; i < 24; i++) begin
            rf  = F_MULT + 6'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            sel = $urandom_range(0, 7);
            if (sel == 0) rb = 32'd0;
            if (sel == 1) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            if (sel == 2) begin ra = 32'($urandom_range(0, 300)) - 32'd150; rb = 32'($urandom_range(1, 20)) - 32'd10; end
            if (sel == 3) mt("rand_mt", 1'($urandom), ra);
            else          run_md("rand_md", rf, ra, rb);
        end

        // Asynchronous reset in busy cycle 3 of a div
        IR = rtype(F_DIV); A = 32'hFFFF_FFF9; B = 32'd2; valid = 1'b1;
        step();
        valid = 1'b0;
        step();
        step();
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_mid_busy", 64'(md_busy), 64'd0);
        chk("rst_mid_hilo", {hi, lo}, 64'd0);
        IR = {6'h0F, 26'($urandom)}; #1;
        chk("rst_decode", 64'({ALUOp, BSel}), 64'({4'd11, 1'b1}));
        @(negedge clk);
        reset_n = 1'b1;
        exp_hi = 32'd0;
        exp_lo = 32'd0;
        for (int i = 0; i < DIV_N + 3; i++) step();
        chk("rst_no_commit", {31'd0, md_busy, hi, lo} , 64'd0);
        run_md("post_rst", F_MULT, 32'h0000_0007, 32'hFFFF_FFFD);
        chk("post_rst_const", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFEB});

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
